// File: rtl/addsub_arbiter.sv
// -----------------------------------------------------------------------------
// addsub_arbiter
//   Shares one 16-bit saturating adder/subtractor between two requesters
//   (ALU side = requester 0, address/PC side = requester 1). Round-robin
//   arbitration under contention, operands latched at grant time, result and
//   overflow registered, one-cycle gnt and done pulses per operation.
//   Op latency is two clock edges; sustained throughput is one op per two
//   cycles.
//
// Ports:
//   clk_i            rising-edge clock
//   rst_i            synchronous reset, active-high
//   req0_i/req1_i    request; held high with operands stable until the grant
//   a0_i/b0_i        requester 0 operands
//   sub0_i           requester 0 op select (1 = A-B, 0 = A+B)
//   a1_i/b1_i        requester 1 operands
//   sub1_i           requester 1 op select
//   gnt0_o/gnt1_o    one-cycle pulse: that requester's operands were latched
//   done0_o/done1_o  one-cycle pulse: result_o/ovf_o valid for that requester
//   result_o         registered result, held until the next done
//   ovf_o            signed overflow on the op reported by result_o
//   busy_o           high while in CALC or RESP
// -----------------------------------------------------------------------------
module addsub_arbiter #(
    parameter int WIDTH  = 16,
    parameter bit SAT_EN = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_i,
    input  logic [WIDTH-1:0] a0_i,
    input  logic [WIDTH-1:0] b0_i,
    input  logic             sub0_i,
    input  logic             req1_i,
    input  logic [WIDTH-1:0] a1_i,
    input  logic [WIDTH-1:0] b1_i,
    input  logic             sub1_i,
    output logic             gnt0_o,
    output logic             gnt1_o,
    output logic             done0_o,
    output logic             done1_o,
    output logic [WIDTH-1:0] result_o,
    output logic             ovf_o,
    output logic             busy_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8000;

    // Shared add/subtract. Returns {ovf, result}. Subtraction is A + ~B + 1;
    // overflow is carry-into-MSB XOR carry-out-of-MSB. On overflow the sign of
    // A tells the direction: add overflows only when A and B share a sign, sub
    // only when A and ~B share a sign, so A's sign is the sign of the true
    // result in both cases.
    function automatic logic [16:0] addsub_f(
        input logic [15:0] a,
        input logic [15:0] b,
        input logic        sub,
        input logic        sat
    );
        logic [15:0] bx;
        logic [16:0] sum;
        logic        c15;
        logic        c16;
        logic        ov;
        logic [15:0] res;
        bx  = sub ? ~b : b;
        sum = {1'b0, a} + {1'b0, bx} + {16'h0000, sub};
        c16 = sum[16];
        c15 = a[15] ^ bx[15] ^ sum[15];
        ov  = c15 ^ c16;
        if (ov && sat) begin
            res = a[15] ? SAT_NEG : SAT_POS;
        end else begin
            res = sum[15:0];
        end
        return {ov, res};
    endfunction

    logic [1:0]       state_q, state_d;
    logic             last_grant_q;   // also identifies the owner of the op in flight
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic             op_sub_q;
    logic             gnt0_q, gnt1_q;
    logic             done0_q, done1_q;
    logic [WIDTH-1:0] result_q;
    logic             ovf_q;
    logic             busy_q;

    logic             any_req_s;
    logic             accept_s;
    logic             calc_s;
    logic             winner_s;
    logic [WIDTH-1:0] sel_a_s;
    logic [WIDTH-1:0] sel_b_s;
    logic             sel_sub_s;
    logic [16:0]      alu_s;

    assign any_req_s = req0_i | req1_i;
    // New ops are only accepted from IDLE or RESP (back-to-back issue).
    assign accept_s  = any_req_s && ((state_q == ST_IDLE) || (state_q == ST_RESP));
    assign calc_s    = (state_q == ST_CALC);
    assign alu_s     = addsub_f(op_a_q, op_b_q, op_sub_q, SAT_EN);

    // Round-robin winner: a sole requester wins; on a tie the one not granted last wins.
    always_comb begin
        winner_s = 1'b0;
        if (req0_i && req1_i) begin
            winner_s = ~last_grant_q;
        end else if (req1_i) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    // Operand mux feeding the operand registers.
    always_comb begin
        sel_a_s   = a0_i;
        sel_b_s   = b0_i;
        sel_sub_s = sub0_i;
        if (winner_s) begin
            sel_a_s   = a1_i;
            sel_b_s   = b1_i;
            sel_sub_s = sub1_i;
        end else begin
            sel_a_s   = a0_i;
            sel_b_s   = b0_i;
            sel_sub_s = sub0_i;
        end
    end

    // Next-state logic for the IDLE -> CALC -> RESP sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (accept_s) begin
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, operand latches, registered handshake pulses and result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_sub_q     <= 1'b0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            result_q     <= '0;
            ovf_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != ST_IDLE);
            gnt0_q  <= accept_s & ~winner_s;
            gnt1_q  <= accept_s &  winner_s;
            done0_q <= calc_s & ~last_grant_q;
            done1_q <= calc_s &  last_grant_q;
            if (accept_s) begin
                op_a_q       <= sel_a_s;
                op_b_q       <= sel_b_s;
                op_sub_q     <= sel_sub_s;
                last_grant_q <= winner_s;
            end
            if (calc_s) begin
                result_q <= alu_s[15:0];
                ovf_q    <= alu_s[16];
            end
        end
    end

    assign gnt0_o   = gnt0_q;
    assign gnt1_o   = gnt1_q;
    assign done0_o  = done0_q;
    assign done1_o  = done1_q;
    assign result_o = result_q;
    assign ovf_o    = ovf_q;
    assign busy_o   = busy_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// -----------------------------------------------------------------------------
// tb_addsub_arbiter
//   Directed-vector bench for addsub_arbiter. Two instances share stimulus:
//   dut (SAT_EN=1) and dut_w (SAT_EN=0). Inputs change 1ns after each rising
//   edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_addsub_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, sub0, req1, sub1;
    logic [15:0] a0, b0, a1, b1;

    logic        gnt0, gnt1, done0, done1, ovf, busy;
    logic [15:0] result;
    logic        w_gnt0, w_gnt1, w_done0, w_done1, w_ovf, w_busy;
    logic [15:0] w_result;

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    addsub_arbiter #(.WIDTH(16), .SAT_EN(1'b1)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_i(req0), .a0_i(a0), .b0_i(b0), .sub0_i(sub0),
        .req1_i(req1), .a1_i(a1), .b1_i(b1), .sub1_i(sub1),
        .gnt0_o(gnt0), .gnt1_o(gnt1), .done0_o(done0), .done1_o(done1),
        .result_o(result), .ovf_o(ovf), .busy_o(busy)
    );

    addsub_arbiter #(.WIDTH(16), .SAT_EN(1'b0)) dut_w (
        .clk_i(clk), .rst_i(rst),
        .req0_i(req0), .a0_i(a0), .b0_i(b0), .sub0_i(sub0),
        .req1_i(req1), .a1_i(a1), .b1_i(b1), .sub1_i(sub1),
        .gnt0_o(w_gnt0), .gnt1_o(w_gnt1), .done0_o(w_done0), .done1_o(w_done1),
        .result_o(w_result), .ovf_o(w_ovf), .busy_o(w_busy)
    );

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Mutual exclusion of grants and dones, on both instances, every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            check("gnt_excl",  {31'd0, gnt0 & gnt1},       32'd0);
            check("done_excl", {31'd0, done0 & done1},     32'd0);
            check("w_excl",    {30'd0, w_gnt0 & w_gnt1, w_done0 & w_done1}, 32'd0);
        end
    end

    // One uncontended op from requester 'who'; checks gnt, done, result, ovf, busy.
    task automatic single_op(input string tag, input logic who,
                             input logic [15:0] a, input logic [15:0] b, input logic sub,
                             input logic [15:0] exp_sat, input logic [15:0] exp_wrap,
                             input logic exp_ovf);
        if (who) begin
            req1 = 1'b1; a1 = a; b1 = b; sub1 = sub;
        end else begin
            req0 = 1'b1; a0 = a; b0 = b; sub0 = sub;
        end
        tick();
        check({tag, "_gnt"},  {30'd0, gnt1, gnt0}, who ? 32'd2 : 32'd1);
        check({tag, "_busy1"}, {31'd0, busy}, 32'd1);
        req0 = 1'b0; req1 = 1'b0;
        tick();
        check({tag, "_done"}, {28'd0, done1, done0, gnt1, gnt0}, who ? 32'd8 : 32'd4);
        check({tag, "_res"},  {16'd0, result},   {16'd0, exp_sat});
        check({tag, "_ovf"},  {31'd0, ovf},      {31'd0, exp_ovf});
        check({tag, "_wres"}, {16'd0, w_result}, {16'd0, exp_wrap});
        check({tag, "_wovf"}, {31'd0, w_ovf},    {31'd0, exp_ovf});
        check({tag, "_busy2"}, {31'd0, busy}, 32'd1);
        tick();
        check({tag, "_idle"}, {29'd0, busy, done1, done0}, 32'd0);
        check({tag, "_hold"}, {16'd0, result}, {16'd0, exp_sat});
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; a0 = 16'h0000; b0 = 16'h0000; sub0 = 1'b0;
        req1 = 1'b0; a1 = 16'h0000; b1 = 16'h0000; sub1 = 1'b0;
        tick();
        tick();
        check("rst_ctl", {26'd0, gnt0, gnt1, done0, done1, busy, ovf}, 32'd0);
        check("rst_res", {16'd0, result}, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Directed vectors: {tag, who, a, b, sub, saturated result, wrapped result, ovf}
        single_op("add",     1'b0, 16'h0005, 16'h0003, 1'b0, 16'h0008, 16'h0008, 1'b0);
        single_op("possat",  1'b1, 16'h7000, 16'h2000, 1'b0, 16'h7FFF, 16'h9000, 1'b1);
        single_op("negsub",  1'b0, 16'h8000, 16'h0001, 1'b1, 16'h8000, 16'h7FFF, 1'b1);
        single_op("zsubmin", 1'b0, 16'h0000, 16'h8000, 1'b1, 16'h7FFF, 16'h8000, 1'b1);
        single_op("minmin",  1'b1, 16'h8000, 16'h8000, 1'b1, 16'h0000, 16'h0000, 1'b0);
        single_op("negadd",  1'b1, 16'h8000, 16'hFFFF, 1'b0, 16'h8000, 16'h7FFF, 1'b1);
        single_op("subneg",  1'b0, 16'h0010, 16'h0020, 1'b1, 16'hFFF0, 16'hFFF0, 1'b0);

        // Contention straight after reset: requester 0 wins the first tie, then alternate.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0 = 1'b1; a0 = 16'h0100; b0 = 16'h0001; sub0 = 1'b0;   // 0x0101
        req1 = 1'b1; a1 = 16'h0200; b1 = 16'h0002; sub1 = 1'b1;   // 0x01FE
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("cont_gnt%0d", i), {30'd0, gnt1, gnt0}, (i % 2 == 1) ? 32'd2 : 32'd1);
            if (i == 3) begin
                req0 = 1'b0; req1 = 1'b0;
            end
            tick();
            check($sformatf("cont_done%0d", i), {28'd0, done1, done0, gnt1, gnt0},
                  (i % 2 == 1) ? 32'd8 : 32'd4);
            check($sformatf("cont_res%0d", i), {16'd0, result},
                  (i % 2 == 1) ? 32'h0000_01FE : 32'h0000_0101);
        end
        tick();
        check("cont_idle", {31'd0, busy}, 32'd0);

        // Reset while in CALC discards the op.
        req0 = 1'b1; a0 = 16'h1234; b0 = 16'h0001; sub0 = 1'b0;
        tick();
        check("mid_gnt", {30'd0, gnt1, gnt0}, 32'd1);
        req0 = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_ctl", {28'd0, done0, done1, busy, ovf}, 32'd0);
        check("mid_res", {16'd0, result}, 32'd0);
        tick();
        check("mid_nodone", {30'd0, done0, done1}, 32'd0);
        single_op("after_rst", 1'b1, 16'h0003, 16'h0004, 1'b0, 16'h0007, 16'h0007, 1'b0);

        // Operand isolation: live inputs change during CALC.
        req0 = 1'b1; a0 = 16'h0011; b0 = 16'h0022; sub0 = 1'b0;
        tick();
        check("iso_gnt", {30'd0, gnt1, gnt0}, 32'd1);
        req0 = 1'b0; a0 = 16'h7777; b0 = 16'h1111; sub0 = 1'b1;
        tick();
        check("iso_done", {31'd0, done0}, 32'd1);
        check("iso_res", {16'd0, result}, 32'h0000_0033);
        tick();
        check("iso_once", {30'd0, done0, busy}, 32'd0);
        check("iso_hold", {16'd0, result}, 32'h0000_0033);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
